// File: rtl/soc_system_stepper_monitor.sv
// Avalon-MM step/dir/enable_n monitor: synchronizes the driver pins, qualifies step
// pulses and keeps a signed position with target compare, overflow and collision flags.
module soc_system_stepper_monitor #(
  parameter int POS_WIDTH   = 32,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [2:0]  in_port,
  output logic        irq
);

  localparam int CW = (MIN_PULSE < 2) ? 1 : $clog2(MIN_PULSE + 1);

  localparam logic [POS_WIDTH-1:0] POS_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
  localparam logic [POS_WIDTH-1:0] POS_MIN = {1'b1, {(POS_WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]        HI_MAX  = CW'(MIN_PULSE);
  localparam logic [CW-1:0]        HI_ARM  = CW'(MIN_PULSE - 1);

  logic [SYNC_STAGES-1:0] sync_step, sync_dir, sync_en_n, sync_fill;
  logic                   step_s, dir_s, en_n_s, sync_valid;

  logic [CW-1:0]          hi_cnt;
  logic                   armed;
  logic                   qualify;

  logic [POS_WIDTH-1:0]   position, target;
  logic [POS_WIDTH-1:0]   pos_stepped;
  logic [3:0]             control;
  logic                   match, overflow, collision;

  logic                   count_en, gate_en, dir_invert, irq_en;
  logic                   apply, step_up, step_wraps;
  logic                   wr, wr_pos, wr_tgt, wr_ctl, wr_sts;
  logic                   set_match, set_ovf, set_col;

  assign count_en   = control[0];
  assign gate_en    = control[1];
  assign dir_invert = control[2];
  assign irq_en     = control[3];

  // Input synchronizers; sync_fill marks when the last stage holds a post-reset sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_step <= '0;
      sync_dir  <= '0;
      sync_en_n <= '0;
      sync_fill <= '0;
    end else begin
      sync_step <= {sync_step[SYNC_STAGES-2:0], in_port[0]};
      sync_dir  <= {sync_dir[SYNC_STAGES-2:0],  in_port[1]};
      sync_en_n <= {sync_en_n[SYNC_STAGES-2:0], in_port[2]};
      sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign step_s     = sync_step[SYNC_STAGES-1];
  assign dir_s      = sync_dir[SYNC_STAGES-1];
  assign en_n_s     = sync_en_n[SYNC_STAGES-1];
  assign sync_valid = sync_fill[SYNC_STAGES-1];

  assign qualify = step_s && armed && (hi_cnt == HI_ARM);

  // Arming only on a genuinely sampled low keeps a step held across reset from counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_cnt <= '0;
      armed  <= 1'b0;
    end else begin
      if (!step_s)
        hi_cnt <= '0;
      else if (hi_cnt != HI_MAX)
        hi_cnt <= hi_cnt + 1'b1;

      if (!step_s && sync_valid)
        armed <= 1'b1;
      else if (qualify)
        armed <= 1'b0;
    end
  end

  assign apply       = qualify && count_en && (!gate_en || !en_n_s);
  assign step_up     = dir_s ^ dir_invert;
  assign pos_stepped = step_up ? position + 1'b1 : position - 1'b1;
  assign step_wraps  = step_up ? (position == POS_MAX) : (position == POS_MIN);

  assign wr     = chipselect && !write_n;
  assign wr_pos = wr && (address == 2'd0);
  assign wr_tgt = wr && (address == 2'd1);
  assign wr_ctl = wr && (address == 2'd2);
  assign wr_sts = wr && (address == 2'd3);

  // A preset wins over a concurrent step; the lost step is reported as a collision.
  assign set_col   = apply && wr_pos;
  assign set_ovf   = apply && !wr_pos && step_wraps;
  assign set_match = apply && !wr_pos && (pos_stepped == target);

  always_ff @(posedge clk) begin
    if (reset) begin
      position <= '0;
      target   <= '0;
      control  <= '0;
    end else begin
      if (wr_pos)
        position <= writedata[POS_WIDTH-1:0];
      else if (apply)
        position <= pos_stepped;

      if (wr_tgt)
        target <= writedata[POS_WIDTH-1:0];

      if (wr_ctl)
        control <= writedata[3:0];
    end
  end

  // Sticky flags: write-1-to-clear, with a same-cycle set taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      match     <= 1'b0;
      overflow  <= 1'b0;
      collision <= 1'b0;
    end else begin
      match     <= set_match || (match     && !(wr_sts && writedata[0]));
      overflow  <= set_ovf   || (overflow  && !(wr_sts && writedata[1]));
      collision <= set_col   || (collision && !(wr_sts && writedata[2]));
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = 32'($signed(position));
      2'd1: readdata = 32'($signed(target));
      2'd2: readdata = {28'd0, control};
      2'd3: readdata = {25'd0, en_n_s, dir_s, step_s, 1'b0, collision, overflow, match};
      default: readdata = '0;
    endcase
  end

  assign irq = match && irq_en;

endmodule

// File: doc/soc_system_stepper_monitor.md
# soc_system_stepper_monitor

Avalon-MM slave that watches the step/dir/enable_n pin triplet driven onto a stepper driver and keeps a signed step position the HPS can read, preset and compare against. It sits on the same lightweight HPS-to-FPGA bus as the stepper output PIOs, with `in_port` wired to the physical driver pins or looped back from a stepper PIO. It gives the processor closed-loop confirmation of how many steps actually left the FPGA, plus an interrupt on reaching a target position.

## Interface

- POS_WIDTH, 32: position/target width, signed two's complement (≤32; readdata sign-extended).
- SYNC_STAGES, 2: synchronizer flops on in_port (≥2).
- MIN_PULSE, 2: consecutive synchronized-high cycles required to qualify a step (≥1).

- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address (read latency 0, no wait states).
- in_port  in  3  [0] step, [1] dir, [2] enable_n; asynchronous.
- irq  out  1  level interrupt = STATUS.match & CONTROL.irq_en.

## Operation

- Register map (write occurs when chipselect & ~write_n):
  - 0 POSITION R/W: current position; write presets it.
  - 1 TARGET R/W: compare value.
  - 2 CONTROL R/W: bit0 count_en, bit1 gate_en, bit2 dir_invert, bit3 irq_en; other bits read 0.
  - 3 STATUS: bit0 match, bit1 overflow, bit2 collision (sticky, write-1-to-clear); bits[6:4] = synchronized {enable_n, dir, step}, read-only; other bits 0.
- in_port passes through SYNC_STAGES flops per bit; all decisions use synchronized values.
- Filter: hi_cnt counts consecutive synchronized-high step cycles, saturating at MIN_PULSE, cleared on low. `armed` is cleared by reset and set whenever synchronized step is low.
- Step qualifies on the cycle hi_cnt goes MIN_PULSE-1 → MIN_PULSE while armed. armed clears on qualify, so a held-high step counts once.
- A qualified step is applied only if count_en = 1 and (gate_en = 0 or synchronized enable_n = 0). Otherwise it is dropped silently.
- Direction: (dir ^ dir_invert) = 1 → +1, 0 → −1. dir is sampled on the qualify cycle.
- Arithmetic wraps modulo 2^POS_WIDTH. A wrap (max→min or min→max) sets overflow.
- match is set when an applied step makes POSITION equal to TARGET. POSITION/TARGET writes never set match.
- Simultaneous POSITION write and applied step: the write value is loaded, the step is lost, and collision is set.
- Simultaneous W1C and set of the same STATUS bit: set wins.

## Timing

- Reset: POSITION = 0, TARGET = 0, CONTROL = 0, STATUS sticky bits = 0, sync flops = 0, hi_cnt = 0, armed = 0, irq = 0, readdata = 0 (address 0).
- Let edge k be the first edge that samples step high. POSITION updates at edge k + SYNC_STAGES + MIN_PULSE − 1; match/overflow set on that same edge; irq is high in the following cycle.
- Register writes take effect at the next edge. A read in the cycle after the write returns the new value.
- A step pulse shorter than MIN_PULSE synchronized cycles, or a step held high across reset release, is never counted.
- Minimum step low time: 1 synchronized cycle to re-arm.
- Reset asserted mid-pulse aborts the pulse (hi_cnt and armed cleared). Reset takes priority over any concurrent write.

## Test plan

- Reset, then CONTROL = 0x1, dir = 1, 5 step pulses of 4 cycles high / 4 low → POSITION reads 5; each update lands 3 edges after step is first sampled high (defaults).
- dir = 0, dir_invert = 0, POSITION preset to 0 → 3 pulses → POSITION = 0xFFFFFFFD. Then preset 0x80000000, 1 pulse → 0x7FFFFFFF, overflow = 1; write 0x2 to STATUS → overflow = 0.
- 1-cycle step glitches (MIN_PULSE = 2) → POSITION unchanged. Step held high for 20 cycles → +1 only. Step high through reset release → 0 counts.
- gate_en = 1, enable_n = 1 with 4 pulses → no change; enable_n = 0 with 4 pulses → +4.
- TARGET = 3, irq_en = 1, 3 pulses up → irq rises 1 cycle after third update; W1C match → irq = 0. TARGET write equal to POSITION → no match.
- POSITION write of 100 on the exact qualify edge → reads 100, collision = 1.
